// File: rtl/tl_sched_pkg.sv
// Shared types and constants for the intersection signal scheduler.
// Lamp codes are {red, amber, green} for a single approach.
package tl_sched_pkg;

    localparam int unsigned N_APPR = 4;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        AMBER   = 2'd2,
        FLASH   = 2'd3
    } state_t;

    localparam logic [2:0] LAMP_RED   = 3'b100;
    localparam logic [2:0] LAMP_AMBER = 3'b010;
    localparam logic [2:0] LAMP_GREEN = 3'b001;
    localparam logic [2:0] LAMP_OFF   = 3'b000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/next_approach_pick.sv
// Chooses the next approach to grant: lowest-index preferential request,
// else round-robin vehicle demand starting after the current approach.
module next_approach_pick
    import tl_sched_pkg::*;
(
    input  logic [3:0] pref,
    input  logic [3:0] demand,
    input  logic [1:0] active,
    output logic [1:0] pick
);

    logic [1:0] w_idx;

    // Loops run from lowest to highest priority so the last hit wins.
    always_comb begin
        pick  = active + 2'd1;
        w_idx = '0;
        if (|pref) begin
            for (int unsigned i = N_APPR; i > 0; i--) begin
                if (pref[2'(i - 1)]) pick = 2'(i - 1);
            end
        end else if (|demand) begin
            for (int unsigned k = N_APPR; k > 0; k--) begin
                w_idx = active + 2'(k);
                if (demand[w_idx]) pick = w_idx;
            end
        end
    end

endmodule

// File: rtl/intersection_scheduler.sv
// Four-approach signal sequencer: one green at a time with amber and
// all-red clearance, preferential priority, demand round-robin, flash mode.
module intersection_scheduler
    import tl_sched_pkg::*;
#(
    parameter int unsigned GREEN_MIN  = 4,
    parameter int unsigned GREEN_MAX  = 16,
    parameter int unsigned AMBER_T    = 3,
    parameter int unsigned ALLRED_T   = 2,
    parameter int unsigned FLASH_HALF = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  demand,
    input  logic [3:0]  pref,
    input  logic        flash_req,
    output logic [11:0] lamps,
    output logic [1:0]  active,
    output logic        green_start
);

    localparam int unsigned TMAX = max_u(GREEN_MAX, max_u(AMBER_T, ALLRED_T));
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned FW   = $clog2(FLASH_HALF + 1);

    localparam logic [TW-1:0] T_GMIN1 = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] T_GMAX1 = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] T_GMAX  = TW'(GREEN_MAX);
    localparam logic [TW-1:0] T_TOP   = TW'(TMAX);
    localparam logic [TW-1:0] T_AM1   = TW'(AMBER_T - 1);
    localparam logic [TW-1:0] T_AR1   = TW'(ALLRED_T - 1);
    localparam logic [FW-1:0] T_FH1   = FW'(FLASH_HALF - 1);

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [1:0]    r_active;
    logic [FW-1:0] r_flash_cnt;
    logic          r_flash_lit;

    logic [1:0] w_pick;
    logic [3:0] w_active_oh;
    logic       w_other_pref;
    logic       w_other_dem;
    logic       w_hold_own;
    logic       w_green_exit;

    next_approach_pick u_pick (
        .pref   (pref),
        .demand (demand),
        .active (r_active),
        .pick   (w_pick)
    );

    assign w_active_oh  = 4'b0001 << r_active;
    assign w_other_pref = |(pref & ~w_active_oh);
    assign w_other_dem  = |(demand & ~w_active_oh);
    assign w_hold_own   = demand[r_active] | pref[r_active];

    // Short exit needs competing pref, or an idle own approach with competing
    // demand; the long exit is blocked only by the holder's own pref.
    assign w_green_exit =
        ((r_timer >= T_GMIN1) && (w_other_pref || (!w_hold_own && w_other_dem))) ||
        ((r_timer >= T_GMAX1) && !pref[r_active] && (w_other_pref || w_other_dem));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ALL_RED;
            r_timer     <= '0;
            r_active    <= 2'd3;
            r_flash_cnt <= '0;
            r_flash_lit <= 1'b1;
        end else if (flash_req) begin
            if (r_state != FLASH) begin
                r_state     <= FLASH;
                r_timer     <= '0;
                r_flash_cnt <= '0;
                r_flash_lit <= 1'b1;
            end else begin
                if (r_timer != T_TOP) r_timer <= r_timer + 1'b1;
                if (r_flash_cnt == T_FH1) begin
                    r_flash_cnt <= '0;
                    r_flash_lit <= ~r_flash_lit;
                end else begin
                    r_flash_cnt <= r_flash_cnt + 1'b1;
                end
            end
        end else begin
            unique case (r_state)
                FLASH: begin
                    r_state <= ALL_RED;
                    r_timer <= '0;
                end
                ALL_RED: begin
                    if (r_timer == T_AR1) begin
                        r_state  <= GREEN;
                        r_timer  <= '0;
                        r_active <= w_pick;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                GREEN: begin
                    if (w_green_exit) begin
                        r_state <= AMBER;
                        r_timer <= '0;
                    end else if (r_timer != T_GMAX) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                AMBER: begin
                    if (r_timer == T_AM1) begin
                        r_state <= ALL_RED;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= ALL_RED;
                    r_timer <= '0;
                end
            endcase
        end
    end

    always_comb begin
        lamps = '0;
        for (int unsigned i = 0; i < N_APPR; i++) begin
            lamps[3*i +: 3] = LAMP_RED;
            unique case (r_state)
                GREEN:   if (2'(i) == r_active) lamps[3*i +: 3] = LAMP_GREEN;
                AMBER:   if (2'(i) == r_active) lamps[3*i +: 3] = LAMP_AMBER;
                FLASH:   lamps[3*i +: 3] = r_flash_lit ? LAMP_AMBER : LAMP_OFF;
                default: lamps[3*i +: 3] = LAMP_RED;
            endcase
        end
    end

    assign active      = r_active;
    assign green_start = (r_state == GREEN) && (r_timer == '0);

endmodule

// File: tb/tb_intersection_scheduler.sv
// Self-checking bench for intersection_scheduler: vector table, directed
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_intersection_scheduler;

    localparam int GMIN = 4;
    localparam int GMAX = 16;
    localparam int AMB  = 3;
    localparam int AR   = 2;
    localparam int FH   = 2;

    localparam logic [11:0] L_ALLRED = 12'h924;
    localparam logic [11:0] L_G0     = 12'h921;
    localparam logic [11:0] L_A0     = 12'h922;
    localparam logic [11:0] L_G1     = 12'h90C;
    localparam logic [11:0] L_A1     = 12'h914;
    localparam logic [11:0] L_G2     = 12'h864;
    localparam logic [11:0] L_FLON   = 12'h492;
    localparam logic [11:0] L_FLOFF  = 12'h000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  demand = '0;
    logic [3:0]  pref = '0;
    logic        flash_req = 1'b0;
    logic [11:0] lamps;
    logic [1:0]  active;
    logic        green_start;

    intersection_scheduler #(
        .GREEN_MIN  (GMIN),
        .GREEN_MAX  (GMAX),
        .AMBER_T    (AMB),
        .ALLRED_T   (AR),
        .FLASH_HALF (FH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .demand      (demand),
        .pref        (pref),
        .flash_req   (flash_req),
        .lamps       (lamps),
        .active      (active),
        .green_start (green_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Behavioural model: mode name, cycles spent in the mode, granted approach.
    string m_mode = "RED";
    int    m_age  = 0;
    int    m_act  = 3;

    function automatic int pick_model(input logic [3:0] d, input logic [3:0] p, input int act);
        if (p != 0) begin
            for (int i = 0; i < 4; i++) if (p[i]) return i;
        end
        if (d != 0) begin
            for (int k = 1; k <= 4; k++) if (d[(act + k) % 4]) return (act + k) % 4;
        end
        return (act + 1) % 4;
    endfunction

    function automatic bit leave_green(input logic [3:0] d, input logic [3:0] p);
        bit others_p = 0;
        bit others_d = 0;
        int served = m_age + 1;
        for (int i = 0; i < 4; i++) begin
            if (i != m_act) begin
                others_p |= p[i];
                others_d |= d[i];
            end
        end
        if (served >= GMIN && others_p) return 1;
        if (served >= GMIN && !d[m_act] && !p[m_act] && others_d) return 1;
        if (served >= GMAX && !p[m_act] && (others_p || others_d)) return 1;
        return 0;
    endfunction

    task automatic model_step(input logic r, input logic [3:0] d, input logic [3:0] p, input logic f);
        if (r) begin
            m_mode = "RED"; m_age = 0; m_act = 3;
        end else if (f) begin
            if (m_mode != "FLS") begin m_mode = "FLS"; m_age = 0; end
            else m_age++;
        end else if (m_mode == "FLS") begin
            m_mode = "RED"; m_age = 0;
        end else if (m_mode == "RED") begin
            if (m_age + 1 >= AR) begin
                m_act = pick_model(d, p, m_act); m_mode = "GRN"; m_age = 0;
            end else m_age++;
        end else if (m_mode == "GRN") begin
            if (leave_green(d, p)) begin m_mode = "AMB"; m_age = 0; end
            else m_age++;
        end else begin
            if (m_age + 1 >= AMB) begin m_mode = "RED"; m_age = 0; end
            else m_age++;
        end
    endtask

    function automatic logic [11:0] model_lamps();
        logic [11:0] v;
        for (int i = 0; i < 4; i++) begin
            v[3*i +: 3] = 3'b100;
            if (m_mode == "GRN" && i == m_act) v[3*i +: 3] = 3'b001;
            if (m_mode == "AMB" && i == m_act) v[3*i +: 3] = 3'b010;
            if (m_mode == "FLS") v[3*i +: 3] = ((m_age / FH) % 2 == 0) ? 3'b010 : 3'b000;
        end
        return v;
    endfunction

    task automatic step(input logic r, input logic [3:0] d, input logic [3:0] p, input logic f);
        rst = r; demand = d; pref = p; flash_req = f;
        @(posedge clk);
        model_step(r, d, p, f);
        #1;
        check("model_lamps", lamps, model_lamps());
        check("model_active", active, m_act);
        check("model_gstart", green_start, (m_mode == "GRN" && m_age == 0));
    endtask

    task automatic wait_gs(input logic [3:0] d, input logic [3:0] p, input int bound, output bit ok);
        ok = 0;
        for (int c = 0; c < bound && !ok; c++) begin
            step(1'b0, d, p, 1'b0);
            if (green_start === 1'b1) ok = 1;
        end
    endtask

    typedef struct {
        logic        r;
        logic [3:0]  d;
        logic [3:0]  p;
        logic        f;
        logic [11:0] lamps;
        logic [1:0]  act;
        logic        gs;
    } vec_t;

    vec_t vt[13];

    initial begin
        bit ok;
        int gcount;
        int last;
        logic [11:0] fl_pat [5];
        bit fl_on;

        // Reset, rest-to-approach-0, then pref[2] cuts green at GREEN_MIN.
        vt[0]  = '{1'b1, 4'h0, 4'h0, 1'b0, L_ALLRED, 2'd3, 1'b0};
        vt[1]  = '{1'b0, 4'h0, 4'h0, 1'b0, L_ALLRED, 2'd3, 1'b0};
        vt[2]  = '{1'b0, 4'h0, 4'h0, 1'b0, L_G0,     2'd0, 1'b1};
        vt[3]  = '{1'b0, 4'h0, 4'h4, 1'b0, L_G0,     2'd0, 1'b0};
        vt[4]  = '{1'b0, 4'h0, 4'h4, 1'b0, L_G0,     2'd0, 1'b0};
        vt[5]  = '{1'b0, 4'h0, 4'h4, 1'b0, L_G0,     2'd0, 1'b0};
        vt[6]  = '{1'b0, 4'h0, 4'h4, 1'b0, L_A0,     2'd0, 1'b0};
        vt[7]  = '{1'b0, 4'h0, 4'h4, 1'b0, L_A0,     2'd0, 1'b0};
        vt[8]  = '{1'b0, 4'h0, 4'h4, 1'b0, L_A0,     2'd0, 1'b0};
        vt[9]  = '{1'b0, 4'h0, 4'h4, 1'b0, L_ALLRED, 2'd0, 1'b0};
        vt[10] = '{1'b0, 4'h0, 4'h4, 1'b0, L_ALLRED, 2'd0, 1'b0};
        vt[11] = '{1'b0, 4'h0, 4'h4, 1'b0, L_G2,     2'd2, 1'b1};
        vt[12] = '{1'b0, 4'h0, 4'h0, 1'b0, L_G2,     2'd2, 1'b0};

        for (int i = 0; i < 13; i++) begin
            step(vt[i].r, vt[i].d, vt[i].p, vt[i].f);
            check("vec_lamps", lamps, vt[i].lamps);
            check("vec_active", active, vt[i].act);
            check("vec_gstart", green_start, vt[i].gs);
        end
        // Rest in green with no requests.
        for (int i = 0; i < 30; i++) step(1'b0, 4'h0, 4'h0, 1'b0);
        check("rest_lamps", lamps, L_G2);

        // Full demand: round-robin at GREEN_MAX, 21-cycle grant period.
        step(1'b1, 4'h0, 4'h0, 1'b0);
        gcount = 0;
        last = -1;
        for (int c = 0; c < 200 && gcount < 5; c++) begin
            step(1'b0, 4'hF, 4'h0, 1'b0);
            if (green_start === 1'b1) begin
                check("rr_active", active, gcount % 4);
                if (last >= 0) check("rr_period", c - last, GMAX + AMB + AR);
                last = c;
                gcount++;
            end
        end
        check("rr_grants", gcount, 5);

        // pref 1010: approach 1 first, then 3 once 1 drops its request.
        step(1'b1, 4'h0, 4'h0, 1'b0);
        wait_gs(4'h0, 4'hA, 10, ok);
        check("pref_first_seen", ok, 1);
        check("pref_first_act", active, 1);
        wait_gs(4'h0, 4'h8, 40, ok);
        check("pref_second_seen", ok, 1);
        check("pref_second_act", active, 3);

        // Flash mid-green, then clearance and resume at active+1.
        step(1'b1, 4'h0, 4'h0, 1'b0);
        wait_gs(4'h0, 4'h0, 10, ok);
        check("flash_pre_green", ok, 1);
        step(1'b0, 4'h0, 4'h0, 1'b0);
        step(1'b0, 4'h0, 4'h0, 1'b0);
        fl_pat = '{L_FLON, L_FLON, L_FLOFF, L_FLOFF, L_FLON};
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'h0, 4'h0, 1'b1);
            check("flash_lamps", lamps, fl_pat[i]);
        end
        step(1'b0, 4'h0, 4'h0, 1'b0);
        check("flash_exit_red0", lamps, L_ALLRED);
        step(1'b0, 4'h0, 4'h0, 1'b0);
        check("flash_exit_red1", lamps, L_ALLRED);
        step(1'b0, 4'h0, 4'h0, 1'b0);
        check("flash_resume", lamps, L_G1);
        check("flash_resume_gs", green_start, 1);

        // Reset during amber: immediate all-red, no further amber.
        step(1'b1, 4'h0, 4'h0, 1'b0);
        wait_gs(4'h2, 4'h0, 10, ok);
        check("rstamb_grant", active, 1);
        ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            step(1'b0, 4'h1, 4'h0, 1'b0);
            if (lamps === L_A1) ok = 1;
        end
        check("rstamb_amber_seen", ok, 1);
        step(1'b1, 4'h1, 4'h0, 1'b1);
        check("rstamb_lamps", lamps, L_ALLRED);
        check("rstamb_active", active, 3);
        check("rstamb_gs", green_start, 0);
        step(1'b0, 4'h0, 4'h0, 1'b0);
        check("rstamb_red", lamps, L_ALLRED);
        step(1'b0, 4'h0, 4'h0, 1'b0);
        check("rstamb_green0", lamps, L_G0);

        // Randomized traffic against the model.
        fl_on = 0;
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] d;
            logic [3:0] p;
            logic r;
            if ($urandom_range(0, 4) == 0) demand = 4'($urandom);
            d = demand;
            p = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
            if (fl_on) fl_on = ($urandom_range(0, 9) != 0);
            else fl_on = ($urandom_range(0, 199) == 0);
            r = ($urandom_range(0, 499) == 0);
            step(r, d, p, fl_on);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
